// File: rtl/alu_tx_pkg.sv
// Shared types for the ALU result drain: FSM states and bytes sent per result.
// ALU_TX_CHECKSUM_EN adds the CHK state, which sends a third byte (lo ^ hi).
package alu_tx_pkg;

`ifdef ALU_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LO, HI, CHK} tx_state_t;
  localparam int BYTES_PER_RESULT = 3;
`else
  typedef enum logic [1:0] {IDLE, LO, HI} tx_state_t;
  localparam int BYTES_PER_RESULT = 2;
`endif

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO that holds ALU results waiting to be serialised.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: a push while full is accepted only if the head pops on the same edge.
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/alu_result_tx.sv
// Queues ALU results and sends each one as WIDTH-bit bytes, low byte first (ALU_TX_CHECKSUM_EN adds lo^hi).
// Latency: a result pushed into an empty queue is offered on tx_data two edges after alu_valid.
// Backpressure: tx_ready low holds the byte; the queue absorbs DEPTH results, further ones pulse overrun.
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_valid,
  output logic [WIDTH-1:0]   tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overrun
);
  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_t          state;
  tx_state_t          state_nxt;
  logic [2*WIDTH-1:0] head;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic               hs;
  logic               last_byte;
  logic               pop;
  logic               more;

  result_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (alu_valid),
    .push_dat (alu_out),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign tx_valid = (state != IDLE);
  assign busy     = tx_valid || !empty;
  assign hs       = tx_valid && tx_ready;
  assign pop      = hs && last_byte;
  // Another entry remains after the pop, counting one written on the same edge.
  assign more     = (count != CW'(1)) || alu_valid;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_byte = 1'b0;
    case (state)
      IDLE: if (!empty) state_nxt = LO;
      LO:   if (hs) state_nxt = HI;
`ifdef ALU_TX_CHECKSUM_EN
      HI:   if (hs) state_nxt = CHK;
      CHK: begin
        last_byte = 1'b1;
        if (hs) state_nxt = more ? LO : IDLE;
      end
`else
      HI: begin
        last_byte = 1'b1;
        if (hs) state_nxt = more ? LO : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_data = '0;
    case (state)
      LO:  tx_data = head[WIDTH-1:0];
      HI:  tx_data = head[2*WIDTH-1:WIDTH];
`ifdef ALU_TX_CHECKSUM_EN
      CHK: tx_data = head[WIDTH-1:0] ^ head[2*WIDTH-1:WIDTH];
`endif
      default: tx_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) overrun <= 1'b0;
    else       overrun <= alu_valid && full && !pop;
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed scenarios plus randomized traffic checked against a queue-based model of the drain stage.
module tb_alu_result_tx;
  import alu_tx_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int BPR   = BYTES_PER_RESULT;

  logic        clk       = 1'b0;
  logic        rstn      = 1'b0;
  logic [15:0] alu_out   = '0;
  logic        alu_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready  = 1'b0;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  alu_result_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .alu_out   (alu_out),
    .alu_valid (alu_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [15:0] r, input int i);
    if (i == 0) return r[7:0];
    if (i == 1) return r[15:8];
    return r[7:0] ^ r[15:8];
  endfunction

  // Reference model: results still owed to the transmitter, in order, and the byte index of the head.
  logic [15:0] rq[$];
  int          bi         = 0;
  logic        exp_ovr    = 1'b0;
  logic        prev_stall = 1'b0;
  bit          mon_en     = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        int sz;
        bit popped;
        check_eq("overrun", 32'(overrun), 32'(exp_ovr));
        check_eq("busy", 32'(busy), 32'(rq.size() != 0));
        if (prev_stall) check_eq("hold_vld", 32'(tx_valid), 32'd1);
        if (tx_valid) begin
          check_eq("vld_no_entry", 32'(rq.size() != 0), 32'd1);
          if (rq.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(byte_of(rq[0], bi)));
        end
        if (!rstn) begin
          rq.delete();
          bi         = 0;
          exp_ovr    = 1'b0;
          prev_stall = 1'b0;
        end else begin
          sz         = rq.size();
          popped     = 1'b0;
          prev_stall = tx_valid && !tx_ready;
          if (tx_valid && tx_ready && sz != 0) begin
            bi++;
            if (bi == BPR) begin
              void'(rq.pop_front());
              bi     = 0;
              popped = 1'b1;
            end
          end
          exp_ovr = 1'b0;
          if (alu_valid) begin
            if (sz < DEPTH || popped) rq.push_back(alu_out);
            else exp_ovr = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, output int nbytes);
    int n;
    n         = 0;
    nbytes    = 0;
    tx_ready  = 1'b1;
    alu_valid = 1'b0;
    while (busy && n < 200) begin
      if (tx_valid && tx_ready) nbytes++;
      tick();
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int nb;

    // Reset state
    rstn = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;
    check_eq("rst_vld",  32'(tx_valid), 32'd0);
    check_eq("rst_dat",  32'(tx_data),  32'd0);
    check_eq("rst_busy", 32'(busy),     32'd0);
    check_eq("rst_ovr",  32'(overrun),  32'd0);
    rstn = 1'b1;
    tick();

    // Single result: latency and byte order
    tx_ready  = 1'b1;
    alu_valid = 1'b1;
    alu_out   = 16'h1234;
    tick();
    alu_valid = 1'b0;
    check_eq("lat_k", 32'(tx_valid), 32'd0);
    tick();
    check_eq("lat_k1", 32'(tx_valid), 32'd1);
    for (int i = 0; i < BPR; i++) begin
      check_eq("single_byte", 32'(tx_data), 32'(byte_of(16'h1234, i)));
      tick();
    end
    check_eq("single_busy", 32'(busy), 32'd0);
    check_eq("single_vld", 32'(tx_valid), 32'd0);

    // Back-pressure hold
    tx_ready  = 1'b0;
    alu_valid = 1'b1;
    alu_out   = 16'hABCD;
    tick();
    alu_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_vld", 32'(tx_valid), 32'd1);
      check_eq("bp_dat", 32'(tx_data), 32'h0CD);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    check_eq("bp_hi", 32'(tx_data), 32'h0AB);
    drain("bp_drain", nb);

    // Overflow: third result dropped
    tx_ready = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      alu_valid = 1'b1;
      alu_out   = 16'(v);
      tick();
      check_eq("ovf_pulse", 32'(overrun), 32'(v == 3));
    end
    alu_valid = 1'b0;
    tick();
    check_eq("ovf_end", 32'(overrun), 32'd0);
    drain("ovf_drain", nb);
    check_eq("ovf_bytes", 32'(nb), 32'(2 * BPR));

    // Full queue: push on the head's final-byte edge is accepted
    tx_ready  = 1'b0;
    alu_valid = 1'b1;
    alu_out   = 16'h1111;
    tick();
    alu_out   = 16'h2222;
    tick();
    alu_valid = 1'b0;
    tx_ready  = 1'b1;
    for (int i = 0; i < BPR - 1; i++) tick();
    check_eq("fp_last_vld", 32'(tx_valid), 32'd1);
    alu_valid = 1'b1;
    alu_out   = 16'h5555;
    tick();
    alu_valid = 1'b0;
    check_eq("fp_no_ovr", 32'(overrun), 32'd0);
    drain("fp_drain", nb);
    check_eq("fp_bytes", 32'(nb), 32'(2 * BPR));

    // Back-to-back results, no gap
    tx_ready  = 1'b1;
    alu_valid = 1'b1;
    alu_out   = 16'hFFFF;
    tick();
    alu_out   = 16'h0000;
    tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 2 * BPR; i++) begin
      check_eq("b2b_vld", 32'(tx_valid), 32'd1);
      check_eq("b2b_dat", 32'(tx_data),
               32'((i < BPR) ? byte_of(16'hFFFF, i) : byte_of(16'h0000, i - BPR)));
      tick();
    end
    check_eq("b2b_busy", 32'(busy), 32'd0);

    // Reset during HI with a second entry queued
    tx_ready  = 1'b0;
    alu_valid = 1'b1;
    alu_out   = 16'h1234;
    tick();
    alu_out   = 16'h5678;
    tick();
    alu_valid = 1'b0;
    tx_ready  = 1'b1;
    tick();
    check_eq("mr_pre_hi", 32'(tx_data), 32'h012);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_eq("mr_vld",  32'(tx_valid), 32'd0);
    check_eq("mr_busy", 32'(busy),     32'd0);
    check_eq("mr_dat",  32'(tx_data),  32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("mr_quiet", 32'(tx_valid), 32'd0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rstn      = ($urandom_range(0, 199) != 0);
      alu_valid = ($urandom_range(0, 99) < 35);
      alu_out   = 16'($urandom);
      tx_ready  = ($urandom_range(0, 99) < 55);
      tick();
    end
    rstn = 1'b1;
    drain("final_drain", nb);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
